pass_sequencer: RTL and testbench
=================================

Name: pass_sequencer

Overview:
- Controller that sequences the shared 3x3 window datapath (median/gaussian/sobel/non-max/hysteresis/quantize units) over the 20x20 pixel register file after image load completes.
- Selects the operation sequence from mode, generates window center coordinates in raster order, and handshakes each window with the datapath.
- Requests a register-file write-back between passes and signals completion to the top-level CHIP FSM.

Parameters:
- IMG_DIM, 20, image side length in pixels; window centers span 1..IMG_DIM-2.
- CW, 5, width of the row/col coordinate outputs; must satisfy 2^CW > IMG_DIM.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse from the load logic (load_end); sampled only in IDLE.
- mode  input  1  0 = EDGE, 1 = COLOR; captured when start is accepted.
- win_valid  output  1  window coordinates and op are valid.
- win_ready  input  1  datapath accepts the current window.
- win_row  output  CW  window center row.
- win_col  output  CW  window center column.
- op  output  3  current operation: 0 MED_FIL, 1 GAU_FIL, 2 SOBEL, 3 NON_MAX, 4 HYSTER, 5 QUANTIZE.
- last_win  output  1  high with win_valid on the final window of a pass.
- wb_req  output  1  request to copy tmp registers back into the image registers.
- wb_ack  input  1  write-back complete.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the full sequence finishes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, win_row=win_col=1, op=0, all other outputs 0, mode latch=0.
- Sequences:
  - EDGE: MED_FIL, GAU_FIL, SOBEL, NON_MAX, HYSTER.
  - COLOR: MED_FIL, GAU_FIL, QUANTIZE.
  - The final op of each sequence is the last pass.
- States:
  - IDLE: busy=0. If start=1, latch mode, op=MED_FIL, go to SETUP. Otherwise stay.
  - SETUP (1 cycle): win_row=win_col=1. Go to SCAN.
  - SCAN: win_valid=1.
    - On win_valid & win_ready: advance win_col. If win_col==IMG_DIM-2, set win_col=1 and increment win_row.
    - win_row/win_col/op stay stable while win_valid=1 and win_ready=0.
    - last_win = (win_row==IMG_DIM-2) & (win_col==IMG_DIM-2).
    - When the last window is accepted: non-final pass goes to WB; final pass goes to FINISH.
  - WB: wb_req=1, held until wb_ack=1. In the ack cycle, advance op to the next in the sequence and go to SETUP. wb_ack outside WB is ignored.
  - FINISH (1 cycle): done=1. Go to IDLE.
- Window count per pass is (IMG_DIM-2)^2 = 324 with default parameters.
- Outputs are registered, except win_valid, last_win, wb_req and done, which decode from the registered state and coordinates.
- start while busy=1 is ignored, and mode changes mid-sequence have no effect.
- Coordinates never leave the range 1..IMG_DIM-2. The row counter does not advance past IMG_DIM-2. After the final window, win_row=win_col=1 is loaded in SETUP.
- Asserting reset mid-pass returns to IDLE immediately. No done pulse; no wb_req.
- Latency with win_ready=1 and wb_ack=1 held:
  - Non-final pass: 1 (SETUP) + 324 (SCAN) + 1 (WB) = 326 cycles.
  - Final pass: 1 + 324 + 1 (FINISH).
  - EDGE total from start-accept to done: 4*326 + 325 = 1629 cycles.
  - COLOR total: 2*326 + 325 = 977 cycles.

Test Plan:
- Reset check: drive reset low mid-SCAN (op=GAU_FIL, row 7) -> outputs go to reset values immediately; busy=0, done never pulses; a fresh start works normally.
- EDGE full run: start with mode=0, win_ready=1, wb_ack=1 -> op order 0,1,2,3,4; 324 windows per pass; wb_req seen exactly 4 times; done at cycle 1629 after start.
- COLOR full run: start with mode=1 -> op order 0,1,5; wb_req seen 2 times; done at cycle 977; last_win high exactly 3 times.
- Backpressure: win_ready toggles 1-0-0-1 -> coordinates/op held stable while stalled; raster order (1,1),(1,2)..(1,18),(2,1)..(18,18) with no skipped or duplicated windows.
- Write-back stall: wb_ack delayed 5 cycles -> wb_req held high for 6 cycles, op unchanged until the ack cycle, then SETUP.
- Spurious inputs: start pulses during SCAN and mode toggles mid-run; wb_ack during SCAN -> no effect on sequence, coordinates or op.

Source files
------------

// File: rtl/pass_sequencer_if.sv
// pass_sequencer_if: window and write-back handshake between the pass sequencer and the window datapath
interface pass_sequencer_if #(parameter int CW = 5);
  logic          win_valid;
  logic          win_ready;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic [2:0]    op;
  logic          last_win;
  logic          wb_req;
  logic          wb_ack;
  modport master(output win_valid, win_row, win_col, op, last_win, wb_req, input win_ready, wb_ack);
  modport slave(input win_valid, win_row, win_col, op, last_win, wb_req, output win_ready, wb_ack);
endinterface

// File: rtl/pass_sequencer.sv
// pass_sequencer: steps the 3x3 window datapath through each filter pass in raster order,
// with a register-file write-back between passes
module pass_sequencer #(
  parameter int IMG_DIM = 20,
  parameter int CW      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  pass_sequencer_if.master win,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, SETUP, SCAN, WB, FINISH} state_t;
  localparam logic [2:0] MED_FIL  = 3'd0;
  localparam logic [2:0] GAU_FIL  = 3'd1;
  localparam logic [2:0] HYSTER   = 3'd4;
  localparam logic [2:0] QUANTIZE = 3'd5;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] EDGE_POS = CW'(IMG_DIM - 2);
  state_t        state, state_n;
  logic [CW-1:0] row, col, row_n, col_n;
  logic [2:0]    op, op_n, op_next;
  logic          mode_q, mode_n, last, final_pass;
  assign last       = (row == EDGE_POS) && (col == EDGE_POS);
  assign final_pass = op == (mode_q ? QUANTIZE : HYSTER);
  // COLOR skips the edge-detection stages and jumps straight to quantize
  assign op_next    = (op == GAU_FIL && mode_q) ? QUANTIZE : op + 3'd1;
  assign win.win_valid = state == SCAN;
  assign win.last_win  = (state == SCAN) && last;
  assign win.wb_req    = state == WB;
  assign win.win_row   = row;
  assign win.win_col   = col;
  assign win.op        = op;
  assign done          = state == FINISH;
  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    op_n    = op;
    mode_n  = mode_q;
    case (state)
      IDLE: if (start) begin
        state_n = SETUP;
        mode_n  = mode;
        op_n    = MED_FIL;
      end
      SETUP: begin
        row_n   = ONE;
        col_n   = ONE;
        state_n = SCAN;
      end
      SCAN: if (win.win_ready) begin
        col_n = (col == EDGE_POS) ? ONE : col + ONE;
        row_n = (col == EDGE_POS && row != EDGE_POS) ? row + ONE : row;
        if (last) state_n = final_pass ? FINISH : WB;
      end
      WB: if (win.wb_ack) begin
        op_n    = op_next;
        state_n = SETUP;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      row    <= ONE;
      col    <= ONE;
      op     <= MED_FIL;
      mode_q <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      row    <= row_n;
      col    <= col_n;
      op     <= op_n;
      mode_q <= mode_n;
      busy   <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_pass_sequencer.sv
// tb_pass_sequencer: directed vectors plus full-run sequences with an independent raster/op model
module tb_pass_sequencer;
  localparam int IMG_DIM = 20;
  localparam int CW = 5;
  localparam int LAST = IMG_DIM - 2;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
  logic busy, done;
  int n_cmp = 0, n_bad = 0;
  pass_sequencer_if #(.CW(CW)) win ();
  pass_sequencer #(.IMG_DIM(IMG_DIM), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .win(win), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    int start, mode, ready, ack;
    int valid, row, col, op, busy;
  } vec_t;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int exp_op(input logic m, input int p);
    return (m && p == 2) ? 5 : p;
  endfunction
  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(win.win_valid), 0);
    check({tag, "_row"}, int'(win.win_row), 1);
    check({tag, "_col"}, int'(win.win_col), 1);
    check({tag, "_op"}, int'(win.op), 0);
    check({tag, "_last"}, int'(win.last_win), 0);
    check({tag, "_wbreq"}, int'(win.wb_req), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask
  task automatic run_seq(input logic m, input bit stall, input int ack_dly, input bit spur, input int exp_cyc);
    int er = 1, ec = 1, p = 0, acc = 0, vc = 0, wbn = 0, wbrun = 0, lastn = 0, notbusy = 0, n = -1;
    int np = m ? 3 : 5;
    bit fin = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic rdy;
    mode = m;
    start = 1'b1;
    win.wb_ack = 1'b0;
    while (!fin && n < 8000) begin
      @(posedge clk); #1;
      n++;
      if (!busy) notbusy++;
      if (win.win_valid) begin
        check("row", int'(win.win_row), er);
        check("col", int'(win.win_col), ec);
        check("op", int'(win.op), exp_op(m, p));
        check("last_win", int'(win.last_win), int'(er == LAST && ec == LAST));
        rdy = stall ? pat[vc % 4] : 1'b1;
        vc++;
        win.win_ready = rdy;
        if (rdy) begin
          acc++;
          if (win.last_win) lastn++;
          if (ec == LAST) begin
            ec = 1;
            er = (er == LAST) ? 1 : er + 1;
          end else ec++;
        end
      end
      if (win.wb_req) begin
        wbrun++;
        check("wb_op", int'(win.op), exp_op(m, p));
        if (wbrun == 1) begin
          wbn++;
          check("pass_windows", acc, (IMG_DIM - 2) * (IMG_DIM - 2));
          acc = 0;
        end
        win.wb_ack = wbrun > ack_dly;
        if (win.wb_ack) p++;
      end else begin
        if (wbrun > 0) begin
          check("wb_len", wbrun, ack_dly + 1);
          check("setup_valid", int'(win.win_valid), 0);
          check("setup_op", int'(win.op), exp_op(m, p));
          wbrun = 0;
        end
        win.wb_ack = spur && (n % 3 == 0);
      end
      if (done) begin
        fin = 1;
        check("final_windows", acc, (IMG_DIM - 2) * (IMG_DIM - 2));
        if (exp_cyc > 0) check("done_cycle", n, exp_cyc);
      end
      start = spur && !fin && (n % 7 == 3);
      if (spur && n % 11 == 0) mode = ~mode;
    end
    start = 1'b0;
    win.wb_ack = 1'b0;
    check("done_seen", int'(fin), 1);
    check("busy_run", notbusy, 0);
    check("passes", p, np - 1);
    check("wb_count", wbn, np - 1);
    check("last_count", lastn, np);
    @(posedge clk); #1;
    check("done_pulse", int'(done), 0);
    check("idle_busy", int'(busy), 0);
  endtask
  initial begin
    vec_t vt[7];
    int k, dn;
    logic [14:0] obs, expv;
    win.win_ready = 1'b0;
    win.wb_ack = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b1;
    // start accept, then backpressure 1-0-0-1 with spurious start/mode/ack while busy
    vt = '{
      '{1, 0, 0, 0, 0, 1, 1, 0, 1},
      '{0, 0, 0, 0, 1, 1, 1, 0, 1},
      '{0, 0, 1, 0, 1, 1, 2, 0, 1},
      '{0, 0, 0, 0, 1, 1, 2, 0, 1},
      '{1, 1, 0, 0, 1, 1, 2, 0, 1},
      '{0, 1, 1, 1, 1, 1, 3, 0, 1},
      '{0, 0, 1, 0, 1, 1, 4, 0, 1}
    };
    for (int i = 0; i < 7; i++) begin
      start = 1'(vt[i].start);
      mode = 1'(vt[i].mode);
      win.win_ready = 1'(vt[i].ready);
      win.wb_ack = 1'(vt[i].ack);
      @(posedge clk); #1;
      obs = {win.win_valid, win.win_row, win.win_col, win.op, busy};
      expv = {1'(vt[i].valid), CW'(vt[i].row), CW'(vt[i].col), 3'(vt[i].op), 1'(vt[i].busy)};
      check($sformatf("vec%0d", i), int'(obs), int'(expv));
    end
    start = 1'b0;
    win.wb_ack = 1'b0;
    reset = 1'b0;
    #1 check_reset_outputs("vec_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    run_seq(1'b0, 1'b0, 0, 1'b0, 1629);
    run_seq(1'b1, 1'b0, 0, 1'b0, 977);
    run_seq(1'b0, 1'b1, 5, 1'b1, 0);
    mode = 1'b0;
    start = 1'b1;
    win.win_ready = 1'b1;
    win.wb_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(win.win_valid && win.op == 3'd1 && win.win_row == CW'(7)) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check("reach_gau_row7", int'(win.win_valid && win.op == 3'd1 && win.win_row == CW'(7)), 1);
    reset = 1'b0;
    #1 check_reset_outputs("mid_rst");
    dn = 0;
    repeat (3) begin
      @(posedge clk); #1;
      dn += int'(done) + int'(win.wb_req) + int'(busy);
    end
    check("rst_quiet", dn, 0);
    reset = 1'b1;
    win.wb_ack = 1'b0;
    run_seq(1'b1, 1'b1, 5, 1'b1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
